// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : PC register, next-PC resolution from execute-stage branch/jump
//               outcome, and the IF/ID pipeline register feeding decode.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [DATA_WIDTH-1:0] imem_addr,
    input  logic [DATA_WIDTH-1:0] imem_rdata,
    input  logic                  stall_f,
    input  logic                  stall_d,
    input  logic                  flush_d,
    input  logic                  jump_e,
    input  logic                  jret_e,
    input  logic                  beq_e,
    input  logic                  bne_e,
    input  logic                  zero_e,
    input  logic [DATA_WIDTH-1:0] pc_target_e,
    input  logic [DATA_WIDTH-1:0] alu_result_e,
    output logic [DATA_WIDTH-1:0] instr_d,
    output logic [DATA_WIDTH-1:0] pc_d,
    output logic [DATA_WIDTH-1:0] pc_plus4_d,
    output logic                  valid_d,
    output logic                  redirect_e,
    output logic                  misalign_err
);

    localparam logic [0:0]            c_BOOT    = 1'b0;
    localparam logic [0:0]            c_RUN     = 1'b1;
    localparam logic [DATA_WIDTH-1:0] c_FOUR    = DATA_WIDTH'(4);
    localparam logic [DATA_WIDTH-1:0] c_LSB_CLR = ~DATA_WIDTH'(1);
    localparam logic [DATA_WIDTH-1:0] c_WRD_CLR = ~DATA_WIDTH'(3);

    logic [0:0]            r_state;
    logic [0:0]            w_state_next;
    logic [DATA_WIDTH-1:0] r_pc_f;
    logic [DATA_WIDTH-1:0] r_instr_d;
    logic [DATA_WIDTH-1:0] r_pc_d;
    logic [DATA_WIDTH-1:0] r_pc_plus4_d;
    logic                  r_valid_d;
    logic                  r_misalign;

    logic                  w_taken;
    logic                  w_redirect;
    logic [DATA_WIDTH-1:0] w_target;
    logic [DATA_WIDTH-1:0] w_pc_plus4;
    logic                  w_run;

    assign w_run      = (r_state == c_RUN);
    assign w_taken    = jump_e | (beq_e & zero_e) | (bne_e & ~zero_e);
    assign w_redirect = w_run & ~rst & (jret_e | w_taken);
    // JALR clears bit 0 of rs1+imm; the PC itself is always forced word-aligned
    assign w_target   = jret_e ? (alu_result_e & c_LSB_CLR) : pc_target_e;
    assign w_pc_plus4 = r_pc_f + c_FOUR;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_BOOT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_BOOT:  w_state_next = c_RUN;
            c_RUN:   w_state_next = c_RUN;
            default: w_state_next = c_BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc_f <= RESET_PC;
        end else if (!w_run) begin
            r_pc_f <= RESET_PC;
        end else if (w_redirect) begin
            r_pc_f <= w_target & c_WRD_CLR;
        end else if (!stall_f) begin
            r_pc_f <= w_pc_plus4;
        end
    end

    // Bubbles keep pc_d/pc_plus4_d so the link value of the last real op survives
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_d    <= NOP_INSTR;
            r_pc_d       <= '0;
            r_pc_plus4_d <= '0;
            r_valid_d    <= 1'b0;
        end else if (!w_run || w_redirect || flush_d) begin
            r_instr_d    <= NOP_INSTR;
            r_valid_d    <= 1'b0;
        end else if (!stall_d) begin
            r_instr_d    <= imem_rdata;
            r_pc_d       <= r_pc_f;
            r_pc_plus4_d <= w_pc_plus4;
            r_valid_d    <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_redirect && (w_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign imem_addr    = r_pc_f;
    assign instr_d      = r_instr_d;
    assign pc_d         = r_pc_d;
    assign pc_plus4_d   = r_pc_plus4_d;
    assign valid_d      = r_valid_d;
    assign redirect_e   = w_redirect;
    assign misalign_err = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Directed stimulus for fetch_stage, checked every cycle against
//               a reference model plus hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] c_NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata;
    logic        stall_f, stall_d, flush_d;
    logic        jump_e, jret_e, beq_e, bne_e, zero_e;
    logic [31:0] pc_target_e, alu_result_e;
    logic [31:0] instr_d, pc_d, pc_plus4_d;
    logic        valid_d, redirect_e, misalign_err;

    int tests = 0;
    int fails = 0;
    bit check_en = 1'b0;

    logic [31:0] m_pc, m_instr, m_pcd, m_pc4d;
    logic        m_valid, m_err, m_run;

    always #5 clk = ~clk;

    fetch_stage #(
        .DATA_WIDTH (32),
        .RESET_PC   (c_RESET_PC),
        .NOP_INSTR  (c_NOP)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .stall_f      (stall_f),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .jump_e       (jump_e),
        .jret_e       (jret_e),
        .beq_e        (beq_e),
        .bne_e        (bne_e),
        .zero_e       (zero_e),
        .pc_target_e  (pc_target_e),
        .alu_result_e (alu_result_e),
        .instr_d      (instr_d),
        .pc_d         (pc_d),
        .pc_plus4_d   (pc_plus4_d),
        .valid_d      (valid_d),
        .redirect_e   (redirect_e),
        .misalign_err (misalign_err)
    );

    // Instruction memory image: word at address a is a*256 + 0x13 (0x13 at address 0)
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a << 8) + 32'h13;
    endfunction

    assign imem_rdata = mem_word(imem_addr);

    function automatic logic m_redirect();
        return !rst && m_run &&
               (jret_e || jump_e || (beq_e && zero_e) || (bne_e && !zero_e));
    endfunction

    function automatic logic [31:0] m_target();
        return jret_e ? {alu_result_e[31:1], 1'b0} : pc_target_e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= c_RESET_PC; m_instr <= c_NOP; m_pcd <= 32'h0; m_pc4d <= 32'h0;
            m_valid <= 1'b0; m_err <= 1'b0; m_run <= 1'b0;
        end else if (!m_run) begin
            m_run <= 1'b1; m_instr <= c_NOP; m_valid <= 1'b0;
        end else begin
            if (m_redirect()) begin
                m_pc <= m_target() - (m_target() % 4);
                if (m_target() % 4 != 0) m_err <= 1'b1;
            end else if (!stall_f) begin
                m_pc <= m_pc + 32'd4;
            end
            if (m_redirect() || flush_d) begin
                m_instr <= c_NOP; m_valid <= 1'b0;
            end else if (!stall_d) begin
                m_instr <= mem_word(m_pc); m_pcd <= m_pc; m_pc4d <= m_pc + 32'd4;
                m_valid <= 1'b1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (check_en) begin
            chk("imem_addr",    imem_addr,            m_pc);
            chk("instr_d",      instr_d,              m_instr);
            chk("pc_d",         pc_d,                 m_pcd);
            chk("pc_plus4_d",   pc_plus4_d,           m_pc4d);
            chk("valid_d",      32'(valid_d),         32'(m_valid));
            chk("misalign_err", 32'(misalign_err),    32'(m_err));
            chk("redirect_e",   32'(redirect_e),      32'(m_redirect()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        stall_f = 0; stall_d = 0; flush_d = 0;
        jump_e = 0; jret_e = 0; beq_e = 0; bne_e = 0; zero_e = 0;
        pc_target_e = 32'h0; alu_result_e = 32'h0;
    endtask

    task automatic jump_to(input logic [31:0] t);
        jump_e = 1; pc_target_e = t;
        step();
        clr();
    endtask

    initial begin
        rst = 1; clr();
        step(); check_en = 1'b1;
        step();
        chk("rst_valid", 32'(valid_d), 32'h0);
        chk("rst_instr", instr_d, c_NOP);
        rst = 0;
        #1 chk("t1_addr0", imem_addr, 32'h0);
        step(); chk("t1_c1_valid", 32'(valid_d), 32'h0); chk("t1_c1_addr", imem_addr, 32'h0);
        step(); chk("t1_c2_instr", instr_d, 32'h13); chk("t1_c2_pcd", pc_d, 32'h0);
        chk("t1_c2_valid", 32'(valid_d), 32'h1); chk("t1_c2_addr", imem_addr, 32'h4);
        step(); chk("t1_c3_addr", imem_addr, 32'h8);

        step(); step();
        chk("t2_pc10", imem_addr, 32'h10);
        beq_e = 1; zero_e = 1; pc_target_e = 32'h40;
        #1 chk("t2_redirect", 32'(redirect_e), 32'h1);
        step(); clr();
        chk("t2_pc40", imem_addr, 32'h40); chk("t2_nop", instr_d, c_NOP);
        chk("t2_valid0", 32'(valid_d), 32'h0);
        jump_to(32'h10);
        beq_e = 1; zero_e = 0; pc_target_e = 32'h40;
        #1 chk("t2_noredirect", 32'(redirect_e), 32'h0);
        step(); clr();
        chk("t2_pc14", imem_addr, 32'h14); chk("t2_valid1", 32'(valid_d), 32'h1);
        chk("t2_pcd10", pc_d, 32'h10);

        bne_e = 1; zero_e = 0; pc_target_e = 32'h80;
        step(); clr();
        chk("t3_pc80", imem_addr, 32'h80);
        jret_e = 1; alu_result_e = 32'h101;
        step(); clr();
        chk("t3_pc100", imem_addr, 32'h100); chk("t3_err0", 32'(misalign_err), 32'h0);
        jump_to(32'h82);
        chk("t3_pc80b", imem_addr, 32'h80); chk("t3_err1", 32'(misalign_err), 32'h1);
        step(); step();
        chk("t3_err_sticky", 32'(misalign_err), 32'h1);

        jump_to(32'h1C);
        step();
        chk("t4_pc20", imem_addr, 32'h20);
        stall_f = 1; stall_d = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_hold_pc", imem_addr, 32'h20);
            chk("t4_hold_instr", instr_d, 32'h1C13);
            chk("t4_hold_pcd", pc_d, 32'h1C);
        end
        jump_e = 1; pc_target_e = 32'h200;
        step(); clr();
        chk("t4_pc200", imem_addr, 32'h200); chk("t4_nop", instr_d, c_NOP);

        step();
        chk("t5_load", instr_d, 32'h0002_0013);
        flush_d = 1; stall_d = 1;
        step(); clr();
        chk("t5_bubble", instr_d, c_NOP); chk("t5_bub_valid", 32'(valid_d), 32'h0);
        chk("t5_pcd_kept", pc_d, 32'h200);
        jump_to(32'hFFFF_FFFC);
        step();
        chk("t5_wrap_pc", imem_addr, 32'h0); chk("t5_wrap_pc4d", pc_plus4_d, 32'h0);
        chk("t5_wrap_pcd", pc_d, 32'hFFFF_FFFC);

        jump_to(32'h300);
        rst = 1; jump_e = 1; pc_target_e = 32'h40;
        #1 chk("t6_rst_noredirect", 32'(redirect_e), 32'h0);
        step(); clr(); rst = 0;
        chk("t6_pc", imem_addr, c_RESET_PC); chk("t6_valid", 32'(valid_d), 32'h0);
        chk("t6_err", 32'(misalign_err), 32'h0); chk("t6_pcd", pc_d, 32'h0);
        step(); chk("t6_boot_pc", imem_addr, 32'h0);
        step(); chk("t6_run_pc", imem_addr, 32'h4);
        step();

        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
